// File: rtl/data_mem_lsu.sv
// Data memory with load/store formatting for the single-cycle RV32I datapath.
// Loads are combinational (same cycle); stores commit on the rising edge.
// Misaligned or illegal accesses are flagged, and the first one is latched
// into sticky fault registers that only reset clears.
module data_mem_lsu #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic        fault_sticky,
  output logic [31:0] fault_addr
);

  localparam int DATA_W = 32;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic              fault_sticky_q, fault_sticky_d;
  logic [DATA_W-1:0] fault_addr_q, fault_addr_d;

  logic [IDX_W-1:0]  idx;
  logic [1:0]        off;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] wr_word_d;
  logic              we_d;
  logic              bad_align;
  logic              load_ok;
  logic              store_ok;

  // Width code 01 is a halfword, 10 a word; bytes are never misaligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] o);
    logic r;
    r = 1'b0;
    case (f3[1:0])
      2'b01:   r = o[0];
      2'b10:   r = (o != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Extract the addressed byte/halfword and sign- or zero-extend it.
  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] w,
                                                 input logic [2:0]        f3,
                                                 input logic [1:0]        o);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [DATA_W-1:0]  r;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    r = '0;
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'h0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'h0, h};
      3'b010:  r = w;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Merge store data into the existing word; untouched lanes keep their value.
  function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] w,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [2:0]        f3,
                                                    input logic [1:0]        o);
    logic [DATA_W-1:0] r;
    r = w;
    case (f3)
      3'b000: r[{o, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (o[1]) r[31:16] = wd[15:0];
        else      r[15:0]  = wd[15:0];
      end
      3'b010:  r = wd;
      default: r = w;
    endcase
    return r;
  endfunction

  assign idx      = addr[IDX_W+1:2];
  assign off      = addr[1:0];
  assign cur_word = mem_q[idx];

  // Access decode, load formatting, store merge and sticky-fault next state.
  always_comb begin
    load_ok        = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b101);
    store_ok       = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    bad_align      = is_misaligned(funct3, off);
    misaligned     = (mem_read | mem_write) &
                     (bad_align | (mem_read & ~load_ok) | (mem_write & ~store_ok));
    read_data      = '0;
    if (mem_read && load_ok && !bad_align) read_data = fmt_load(cur_word, funct3, off);
    we_d           = mem_write & store_ok & ~bad_align;
    wr_word_d      = merge_store(cur_word, write_data, funct3, off);
    fault_sticky_d = fault_sticky_q;
    fault_addr_d   = fault_addr_q;
    if (misaligned && !fault_sticky_q) begin
      fault_sticky_d = 1'b1;
      fault_addr_d   = addr;
    end
  end

  // Memory array and fault registers; reset clears everything and drops any store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      fault_sticky_q <= 1'b0;
      fault_addr_q   <= '0;
    end else begin
      if (we_d) mem_q[idx] <= wr_word_d;
      fault_sticky_q <= fault_sticky_d;
      fault_addr_q   <= fault_addr_d;
    end
  end

  assign fault_sticky = fault_sticky_q;
  assign fault_addr   = fault_addr_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: byte-level reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_data_mem_lsu;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        misaligned;
  logic        fault_sticky;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] mdl [DEPTH];
  logic        m_sticky;
  logic [31:0] m_faddr;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .write_data(write_data),
    .read_data(read_data), .misaligned(misaligned),
    .fault_sticky(fault_sticky), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_load_legal(input logic [2:0] f3);
    return (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
  endfunction

  function automatic bit m_store_legal(input logic [2:0] f3);
    return f3 < 3;
  endfunction

  function automatic bit m_unaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic bit m_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (rd && !m_load_legal(f3)) return 1'b1;
    if (wr && !m_store_legal(f3)) return 1'b1;
    return m_unaligned(f3, a);
  endfunction

  function automatic logic [31:0] m_load(input logic rd, input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] v;
    int unsigned sh;
    if (!rd || !m_load_legal(f3) || m_unaligned(f3, a)) return 32'h0;
    w  = mdl[(a / 4) % DEPTH];
    sh = 8 * (a % 4);
    v  = 32'h0;
    case (f3)
      3'd0: begin v = (w >> sh) & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
      3'd4: v = (w >> sh) & 32'hFF;
      3'd1: begin v = (w >> sh) & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
      3'd5: v = (w >> sh) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  // Reference model state update on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
      m_sticky = 1'b0;
      m_faddr  = 32'h0;
      chk_en   = 1'b1;
    end else if (chk_en) begin
      if (m_fault(mem_read, mem_write, funct3, addr) && !m_sticky) begin
        m_sticky = 1'b1;
        m_faddr  = addr;
      end
      if (mem_write && m_store_legal(funct3) && !m_unaligned(funct3, addr)) begin
        logic [31:0] w;
        int unsigned pos;
        w = mdl[(addr / 4) % DEPTH];
        for (int i = 0; i < int'(m_size(funct3)); i++) begin
          pos = (addr % 4) + i;
          w[8*pos +: 8] = write_data[8*i +: 8];
        end
        mdl[(addr / 4) % DEPTH] = w;
      end
    end
  end

  // Every-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_read_data", read_data, m_load(mem_read, funct3, addr));
      check("mdl_misaligned", {31'h0, misaligned},
            {31'h0, m_fault(mem_read, mem_write, funct3, addr)});
      check("mdl_fault_sticky", {31'h0, fault_sticky}, {31'h0, m_sticky});
      check("mdl_fault_addr", fault_addr, m_faddr);
    end
  end

  task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    write_data = wd;
    #1;
  endtask

  initial begin
    // 1: reset clear
    @(posedge clk); #1 rst = 1'b1;
    op(1, 0, 3'b010, 32'h00, 32'h0);
    check("t1_lw00", read_data, 32'h0);
    check("t1_sticky", {31'h0, fault_sticky}, 32'h0);
    check("t1_faddr", fault_addr, 32'h0);
    op(1, 0, 3'b010, 32'h04, 32'h0);
    check("t1_lw04", read_data, 32'h0);
    op(1, 0, 3'b010, 32'hFC, 32'h0);
    check("t1_lwfc", read_data, 32'h0);

    // 2: byte-lane merge
    op(0, 1, 3'b010, 32'h10, 32'h11223344);
    op(0, 1, 3'b000, 32'h11, 32'h000000AA);
    op(0, 1, 3'b001, 32'h12, 32'h0000BEEF);
    op(1, 0, 3'b010, 32'h10, 32'h0);
    check("t2_merge", read_data, 32'hBEEFAA44);
    op(0, 0, 3'b010, 32'h10, 32'h0);
    check("t2_noread", read_data, 32'h0);

    // 3: sign/zero extension
    op(0, 1, 3'b010, 32'h20, 32'h80FF7F01);
    op(1, 0, 3'b000, 32'h22, 32'h0);
    check("t3_lb22", read_data, 32'hFFFFFFFF);
    op(1, 0, 3'b100, 32'h22, 32'h0);
    check("t3_lbu22", read_data, 32'h000000FF);
    op(1, 0, 3'b001, 32'h22, 32'h0);
    check("t3_lh22", read_data, 32'hFFFF80FF);
    op(1, 0, 3'b101, 32'h22, 32'h0);
    check("t3_lhu22", read_data, 32'h000080FF);
    op(1, 0, 3'b000, 32'h20, 32'h0);
    check("t3_lb20", read_data, 32'h00000001);
    op(1, 0, 3'b000, 32'h21, 32'h0);
    check("t3_lb21", read_data, 32'h0000007F);

    // 4: misaligned store and sticky fault
    op(0, 1, 3'b010, 32'h31, 32'hDEADBEEF);
    check("t4_mis_sw", {31'h0, misaligned}, 32'h1);
    op(1, 0, 3'b010, 32'h30, 32'h0);
    check("t4_word30", read_data, 32'h0);
    check("t4_sticky", {31'h0, fault_sticky}, 32'h1);
    check("t4_faddr", fault_addr, 32'h31);
    op(1, 0, 3'b001, 32'h45, 32'h0);
    check("t4_mis_lh", {31'h0, misaligned}, 32'h1);
    check("t4_lh_data", read_data, 32'h0);
    op(0, 0, 3'b010, 32'h31, 32'h0);
    check("t4_idle_mis", {31'h0, misaligned}, 32'h0);
    check("t4_faddr_kept", fault_addr, 32'h31);

    // 5: read-before-write and address wrap
    op(1, 1, 3'b010, 32'h100, 32'h12345678);
    check("t5_rbw", read_data, 32'h0);
    op(1, 0, 3'b010, 32'h000, 32'h0);
    check("t5_wrap", read_data, 32'h12345678);

    // 6: reset mid-store, then illegal store
    op(0, 1, 3'b010, 32'h08, 32'hCAFEF00D);
    rst = 1'b1;
    op(1, 0, 3'b010, 32'h08, 32'h0);
    check("t6_rst_store", read_data, 32'h0);
    check("t6_rst_sticky", {31'h0, fault_sticky}, 32'h0);
    check("t6_rst_faddr", fault_addr, 32'h0);
    op(1, 0, 3'b010, 32'h10, 32'h0);
    check("t6_rst_mem", read_data, 32'h0);
    op(0, 1, 3'b011, 32'h40, 32'hFFFFFFFF);
    check("t6_illegal_mis", {31'h0, misaligned}, 32'h1);
    op(1, 0, 3'b010, 32'h40, 32'h0);
    check("t6_illegal_nowr", read_data, 32'h0);
    check("t6_illegal_faddr", fault_addr, 32'h40);
    op(1, 0, 3'b110, 32'h40, 32'h0);
    check("t6_illegal_ld", {31'h0, misaligned}, 32'h1);

    op(0, 0, 3'b000, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
